// File: rtl/m_stage_dm.sv
// Memory stage: decodes loads/stores, accesses a word-organised data memory, registers M->W results.
// Optional DM_ALIGN_CHECK_EN: flags misaligned lw/sw/lh/lhu/sh, suppressing the store and zeroing load data.
module m_stage_dm #(
  parameter int DM_WORDS = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_M,
  input  logic [31:0] PC8_M,
  input  logic [31:0] AO_M,
  input  logic [31:0] RT_M,
  output logic [31:0] IR_W,
  output logic [31:0] PC8_W,
  output logic [31:0] AO_W,
  output logic [31:0] DR_W,
  output logic        dm_err
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  logic [31:0] mem_q [DM_WORDS];
  logic [31:0] ir_q, pc8_q, ao_q, dr_q;
  logic        err_q;

  logic [5:0]        op;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rword, rshift, dr_d, wdata;
  logic [3:0]        be;
  logic              misal;

  assign op     = IR_M[31:26];
  assign idx    = AO_M[ADDR_W+1:2];
  assign rword  = mem_q[idx];
  assign rshift = rword >> {AO_M[1:0], 3'b000};

  always_comb begin
    dr_d  = '0;
    be    = 4'b0000;
    wdata = '0;
    misal = 1'b0;
    unique case (op)
      OP_LW:  dr_d = rword;
      OP_LB:  dr_d = {{24{rshift[7]}}, rshift[7:0]};
      OP_LBU: dr_d = {24'h0, rshift[7:0]};
      OP_LH:  dr_d = AO_M[1] ? {{16{rword[31]}}, rword[31:16]} : {{16{rword[15]}}, rword[15:0]};
      OP_LHU: dr_d = AO_M[1] ? {16'h0, rword[31:16]} : {16'h0, rword[15:0]};
      OP_SW: begin
        be    = 4'b1111;
        wdata = RT_M;
      end
      OP_SH: begin
        be    = AO_M[1] ? 4'b1100 : 4'b0011;
        wdata = {2{RT_M[15:0]}};
      end
      OP_SB: begin
        be    = 4'b0001 << AO_M[1:0];
        wdata = {4{RT_M[7:0]}};
      end
      default: ;
    endcase
`ifdef DM_ALIGN_CHECK_EN
    if (op == OP_LW || op == OP_SW)
      misal = |AO_M[1:0];
    else if (op == OP_LH || op == OP_LHU || op == OP_SH)
      misal = AO_M[0];
    if (misal) begin
      be   = 4'b0000;
      dr_d = '0;
    end
`endif
  end

  // Reset clears the whole array and overrides any store issued in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= '0;
      ir_q  <= '0;
      pc8_q <= 32'h0000_3008;
      ao_q  <= '0;
      dr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      ir_q  <= IR_M;
      pc8_q <= PC8_M;
      ao_q  <= AO_M;
      dr_q  <= dr_d;
      err_q <= misal;
    end
  end

  assign IR_W   = ir_q;
  assign PC8_W  = pc8_q;
  assign AO_W   = ao_q;
  assign DR_W   = dr_q;
  assign dm_err = err_q;

endmodule

// File: tb/tb_m_stage_dm.sv
// Scoreboard bench for m_stage_dm: stimulus pushes expected W-stage values, a monitor pops and compares.
module tb_m_stage_dm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] IR_M = '0, PC8_M = '0, AO_M = '0, RT_M = '0;
  logic [31:0] IR_W, PC8_W, AO_W, DR_W;
  logic        dm_err;

  m_stage_dm dut (
    .clk(clk), .reset(reset),
    .IR_M(IR_M), .PC8_M(PC8_M), .AO_M(AO_M), .RT_M(RT_M),
    .IR_W(IR_W), .PC8_W(PC8_W), .AO_W(AO_W), .DR_W(DR_W), .dm_err(dm_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ir, pc8, ao, dr;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, failures = 0;
  logic [31:0] pc = 32'h0000_3000;

  function automatic logic [31:0] mk(input logic [5:0] op);
    return {op, 26'h0A5_0000};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", nm, act, req);
    end
  endtask

  task automatic issue(input logic rst, input logic [31:0] ir, input logic [31:0] ao,
                       input logic [31:0] rt, input logic [31:0] dr, input logic err);
    exp_t e;
    @(negedge clk);
    reset = rst; IR_M = ir; AO_M = ao; RT_M = rt; PC8_M = pc;
    if (rst) e = '{ir: 32'h0, pc8: 32'h0000_3008, ao: 32'h0, dr: 32'h0, err: 1'b0};
    else     e = '{ir: ir, pc8: pc, ao: ao, dr: dr, err: err};
    exp_q.push_back(e);
    pc += 4;
  endtask

  // Monitor: each pushed vector appears on the outputs after the following posedge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("IR_W",  IR_W,  e.ir);
        chk("PC8_W", PC8_W, e.pc8);
        chk("AO_W",  AO_W,  e.ao);
        chk("DR_W",  DR_W,  e.dr);
        chk("dm_err", {31'h0, dm_err}, {31'h0, e.err});
      end
    end
  end

  localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101, LB = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100, SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;

  initial begin
    // reset cycles, including a store that reset must override
    issue(1, mk(SW), 32'h30, 32'hDEAD_BEEF, 0, 0);
    issue(1, mk(SW), 32'h30, 32'hDEAD_BEEF, 0, 0);
    issue(0, mk(LW),  32'h0,  32'h0, 32'h0, 0);
    issue(0, mk(SW),  32'h10, 32'h8899_AABB, 32'h0, 0);
    issue(0, mk(LW),  32'h10, 32'h0, 32'h8899_AABB, 0);
    issue(0, mk(SB),  32'h13, 32'h0000_00F0, 32'h0, 0);
    issue(0, mk(LW),  32'h10, 32'h0, 32'hF099_AABB, 0);
    issue(0, mk(LB),  32'h13, 32'h0, 32'hFFFF_FFF0, 0);
    issue(0, mk(LBU), 32'h13, 32'h0, 32'h0000_00F0, 0);
    issue(0, mk(LB),  32'h10, 32'h0, 32'hFFFF_FFBB, 0);
    issue(0, mk(LBU), 32'h11, 32'h0, 32'h0000_00AA, 0);
    issue(0, mk(SH),  32'h22, 32'h0000_8001, 32'h0, 0);
    issue(0, mk(LH),  32'h22, 32'h0, 32'hFFFF_8001, 0);
    issue(0, mk(LHU), 32'h22, 32'h0, 32'h0000_8001, 0);
    issue(0, mk(LW),  32'h20, 32'h0, 32'h8001_0000, 0);
    issue(0, mk(SH),  32'h20, 32'hABCD_7FFF, 32'h0, 0);
    issue(0, mk(LH),  32'h20, 32'h0, 32'h0000_7FFF, 0);
    issue(0, mk(LW),  32'h20, 32'h0, 32'h8001_7FFF, 0);
    issue(0, mk(SW),  32'h1004, 32'h1234_5678, 32'h0, 0);
    issue(0, mk(LW),  32'h4,  32'h0, 32'h1234_5678, 0);
    issue(0, {6'h00, 20'h12345, 6'h21}, 32'h0000_DEAD, 32'h5555_5555, 32'h0, 0);
    issue(0, 32'h0,   32'h10, 32'hFFFF_FFFF, 32'h0, 0);
    issue(0, mk(LW),  32'h30, 32'h0, 32'h0, 0);
    issue(0, mk(LW),  32'h10, 32'h0, 32'hF099_AABB, 0);
`ifdef DM_ALIGN_CHECK_EN
    issue(0, mk(SW),  32'h11, 32'hCAFE_BABE, 32'h0, 1);
    issue(0, mk(LW),  32'h10, 32'h0, 32'hF099_AABB, 0);
    issue(0, mk(LH),  32'h21, 32'h0, 32'h0, 1);
    issue(0, mk(LW),  32'h12, 32'h0, 32'h0, 1);
    issue(0, mk(SH),  32'h23, 32'h0000_1111, 32'h0, 1);
    issue(0, mk(LW),  32'h20, 32'h0, 32'h8001_7FFF, 0);
`else
    issue(0, mk(SW),  32'h11, 32'hCAFE_BABE, 32'h0, 0);
    issue(0, mk(LW),  32'h13, 32'h0, 32'hCAFE_BABE, 0);
    issue(0, mk(LH),  32'h21, 32'h0, 32'h0000_7FFF, 0);
    issue(0, mk(LHU), 32'h23, 32'h0, 32'h0000_8001, 0);
`endif
    issue(1, mk(SW),  32'h10, 32'h1, 0, 0);
    issue(0, mk(LW),  32'h10, 32'h0, 32'h0, 0);
    issue(0, mk(LW),  32'h4,  32'h0, 32'h0, 0);
    // drain scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
